// File: rtl/periph_pkg.sv
// Shared definitions for the memory-mapped I/O peripheral: page map, select enum
// and the byte-lane helpers used by the decoder and write path.
package periph_pkg;

    localparam logic [31:0] PERIPH_LEDR_BASE   = 32'h1000_0000;
    localparam logic [31:0] PERIPH_LEDG_BASE   = 32'h1000_1000;
    localparam logic [31:0] PERIPH_HEX_LO_BASE = 32'h1000_2000;
    localparam logic [31:0] PERIPH_HEX_HI_BASE = 32'h1000_3000;
    localparam logic [31:0] PERIPH_LCD_BASE    = 32'h1000_4000;
    localparam logic [31:0] PERIPH_SW_BASE     = 32'h1001_0000;

    localparam logic [6:0] HEX_RESET = 7'h7F;

    typedef enum logic [2:0] {
        NONE,
        LEDR,
        LEDG,
        HEX_LO,
        HEX_HI,
        LCD,
        SW
    } periph_sel_e;

    // Only the page number matters; offsets within a page alias to the same register.
    function automatic periph_sel_e periph_decode(input logic [19:0] page);
        periph_sel_e sel;
        sel = NONE;
        if (page == PERIPH_LEDR_BASE[31:12])        sel = LEDR;
        else if (page == PERIPH_LEDG_BASE[31:12])   sel = LEDG;
        else if (page == PERIPH_HEX_LO_BASE[31:12]) sel = HEX_LO;
        else if (page == PERIPH_HEX_HI_BASE[31:12]) sel = HEX_HI;
        else if (page == PERIPH_LCD_BASE[31:12])    sel = LCD;
        else if (page == PERIPH_SW_BASE[31:12])     sel = SW;
        return sel;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  bmask);
        logic [31:0] res;
        res = old_word;
        for (int n = 0; n < 4; n++) begin
            if (bmask[n]) res[8*n +: 8] = new_word[8*n +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] pack_hex(input logic [6:0] h3, input logic [6:0] h2,
                                             input logic [6:0] h1, input logic [6:0] h0);
        return {1'b0, h3, 1'b0, h2, 1'b0, h1, 1'b0, h0};
    endfunction

endpackage

// File: rtl/output_periph_if.sv
// LSU-side bus of the I/O peripheral: the core drives the access, the block
// answers with combinational read data and a decode hit.
interface output_periph_if;

    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic [3:0]  i_lsu_bmask;
    logic        i_lsu_wren;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_hit;

    modport master (
        output i_lsu_addr,
        output i_lsu_wdata,
        output i_lsu_bmask,
        output i_lsu_wren,
        input  o_lsu_rdata,
        input  o_lsu_hit
    );

    modport slave (
        input  i_lsu_addr,
        input  i_lsu_wdata,
        input  i_lsu_bmask,
        input  i_lsu_wren,
        output o_lsu_rdata,
        output o_lsu_hit
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous inputs; no debouncing, every bit
// travels the chain independently.
module sync_ff #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) chain_q[i] <= '0;
        end else begin
            chain_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/output_periph.sv
// Memory-mapped LED / seven-segment / LCD output registers plus synchronised
// switch input, decoded from LSU accesses in the I/O region.
module output_periph
    import periph_pkg::*;
#(
    parameter int unsigned P_SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output_periph_if.slave    lsu,
    input  logic [31:0]       i_io_sw,
    output logic [31:0]       o_io_ledr,
    output logic [31:0]       o_io_ledg,
    output logic [6:0]        o_io_hex0,
    output logic [6:0]        o_io_hex1,
    output logic [6:0]        o_io_hex2,
    output logic [6:0]        o_io_hex3,
    output logic [6:0]        o_io_hex4,
    output logic [6:0]        o_io_hex5,
    output logic [6:0]        o_io_hex6,
    output logic [6:0]        o_io_hex7,
    output logic [31:0]       o_io_lcd
);

    periph_sel_e sel;
    logic [31:0] ledr_q, ledr_d;
    logic [31:0] ledg_q, ledg_d;
    logic [31:0] lcd_q, lcd_d;
    logic [6:0]  hex_q [8];
    logic [6:0]  hex_d [8];
    logic [31:0] hex_lo_word, hex_hi_word;
    logic [31:0] hex_lo_new, hex_hi_new;
    logic [31:0] sw_sync;
    logic        unused_addr;

    assign unused_addr = ^lsu.i_lsu_addr[11:0];

    sync_ff #(
        .WIDTH  (32),
        .STAGES (P_SYNC_STAGES)
    ) u_sw_sync (
        .clk (i_clk),
        .rst (i_reset),
        .d   (i_io_sw),
        .q   (sw_sync)
    );

    always_comb begin
        sel         = periph_decode(lsu.i_lsu_addr[31:12]);
        hex_lo_word = pack_hex(hex_q[3], hex_q[2], hex_q[1], hex_q[0]);
        hex_hi_word = pack_hex(hex_q[7], hex_q[6], hex_q[5], hex_q[4]);
        hex_lo_new  = byte_merge(hex_lo_word, lsu.i_lsu_wdata, lsu.i_lsu_bmask);
        hex_hi_new  = byte_merge(hex_hi_word, lsu.i_lsu_wdata, lsu.i_lsu_bmask);
        ledr_d      = ledr_q;
        ledg_d      = ledg_q;
        lcd_d       = lcd_q;
        for (int i = 0; i < 8; i++) hex_d[i] = hex_q[i];

        // SW and undecoded pages fall through to default: stores there are dropped.
        if (lsu.i_lsu_wren) begin
            case (sel)
                LEDR:    ledr_d = byte_merge(ledr_q, lsu.i_lsu_wdata, lsu.i_lsu_bmask);
                LEDG:    ledg_d = byte_merge(ledg_q, lsu.i_lsu_wdata, lsu.i_lsu_bmask);
                LCD:     lcd_d  = byte_merge(lcd_q, lsu.i_lsu_wdata, lsu.i_lsu_bmask);
                HEX_LO: begin
                    for (int i = 0; i < 4; i++) hex_d[i] = hex_lo_new[8*i +: 7];
                end
                HEX_HI: begin
                    for (int i = 0; i < 4; i++) hex_d[i+4] = hex_hi_new[8*i +: 7];
                end
                default: ;
            endcase
        end
    end

    // Read path sees register state only, so a same-cycle store is not forwarded.
    always_comb begin
        lsu.o_lsu_hit = (sel != NONE);
        case (sel)
            LEDR:    lsu.o_lsu_rdata = ledr_q;
            LEDG:    lsu.o_lsu_rdata = ledg_q;
            HEX_LO:  lsu.o_lsu_rdata = hex_lo_word;
            HEX_HI:  lsu.o_lsu_rdata = hex_hi_word;
            LCD:     lsu.o_lsu_rdata = lcd_q;
            SW:      lsu.o_lsu_rdata = sw_sync;
            default: lsu.o_lsu_rdata = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            for (int i = 0; i < 8; i++) hex_q[i] <= HEX_RESET;
        end else begin
            ledr_q <= ledr_d;
            ledg_q <= ledg_d;
            lcd_q  <= lcd_d;
            for (int i = 0; i < 8; i++) hex_q[i] <= hex_d[i];
        end
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hex_q[0];
    assign o_io_hex1 = hex_q[1];
    assign o_io_hex2 = hex_q[2];
    assign o_io_hex3 = hex_q[3];
    assign o_io_hex4 = hex_q[4];
    assign o_io_hex5 = hex_q[5];
    assign o_io_hex6 = hex_q[6];
    assign o_io_hex7 = hex_q[7];

endmodule

// File: tb/tb_output_periph.sv
// Directed bench for output_periph: expected values go into a scoreboard queue
// as stimulus is applied and are popped when the outputs are sampled.
module tb_output_periph;

    localparam logic [31:0] A_LEDR  = 32'h1000_0000;
    localparam logic [31:0] A_LEDG  = 32'h1000_1000;
    localparam logic [31:0] A_HEXLO = 32'h1000_2000;
    localparam logic [31:0] A_HEXHI = 32'h1000_3000;
    localparam logic [31:0] A_LCD   = 32'h1000_4000;
    localparam logic [31:0] A_SW    = 32'h1001_0000;
    localparam logic [31:0] A_NONE  = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] sw;
    logic [31:0] ledr, ledg, lcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

    always #5 clk = ~clk;

    output_periph_if bus ();

    output_periph #(
        .P_SYNC_STAGES (2)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .lsu       (bus.slave),
        .i_io_sw   (sw),
        .o_io_ledr (ledr),
        .o_io_ledg (ledg),
        .o_io_hex0 (hex0),
        .o_io_hex1 (hex1),
        .o_io_hex2 (hex2),
        .o_io_hex3 (hex3),
        .o_io_hex4 (hex4),
        .o_io_hex5 (hex5),
        .o_io_hex6 (hex6),
        .o_io_hex7 (hex7),
        .o_io_lcd  (lcd)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %h required a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [63:0] hex_all();
        return {8'h00, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask);
        @(negedge clk);
        bus.i_lsu_addr  = addr;
        bus.i_lsu_wdata = data;
        bus.i_lsu_bmask = mask;
        bus.i_lsu_wren  = 1'b1;
        @(negedge clk);
        bus.i_lsu_wren  = 1'b0;
    endtask

    task automatic read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        bus.i_lsu_addr = addr;
        bus.i_lsu_wren = 1'b0;
        #1;
        data = bus.o_lsu_rdata;
        hit  = bus.o_lsu_hit;
    endtask

    logic [31:0] rd;
    logic        hit;

    initial begin
        bus.i_lsu_addr  = '0;
        bus.i_lsu_wdata = '0;
        bus.i_lsu_bmask = '0;
        bus.i_lsu_wren  = 1'b0;
        sw              = '0;

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        push("rst_ledr", 64'h0); check(ledr);
        push("rst_ledg", 64'h0); check(ledg);
        push("rst_lcd", 64'h0);  check(lcd);
        push("rst_hex", {8'h00, {8{7'h7F}}}); check(hex_all());
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // LEDR byte store over a full-word background.
        store(A_LEDR, 32'h1234_5600, 4'hF);
        store(A_LEDR, 32'h0000_0041, 4'b0001);
        push("ledr_byte", 64'h1234_5641); check(ledr);
        read(A_LEDR + 32'hABC, rd, hit);
        push("ledr_alias_rd", 64'h1234_5641); check(rd);
        push("ledr_hit", 64'h1); check(hit);

        // Partial merge on LEDG.
        store(A_LEDG, 32'hAABB_CCDD, 4'hF);
        store(A_LEDG, 32'h1122_3344, 4'b1010);
        push("ledg_merge", 64'h11BB_33DD); check(ledg);
        read(32'h1000_1FFC, rd, hit);
        push("ledg_rd", 64'h11BB_33DD); check(rd);

        // HEX_HI lanes drop bit 7.
        store(A_HEXHI, 32'hFF80_C0F9, 4'hF);
        push("hex_lanes", {8'h00, 7'h7F, 7'h00, 7'h40, 7'h79, {4{7'h7F}}}); check(hex_all());
        read(A_HEXHI, rd, hit);
        push("hexhi_rd", 64'h7F00_4079); check(rd);
        read(A_HEXLO, rd, hit);
        push("hexlo_rd", 64'h7F7F_7F7F); check(rd);

        // Zero byte mask leaves state alone.
        store(A_LEDR, 32'hFFFF_FFFF, 4'h0);
        push("bmask0_ledr", 64'h1234_5641); check(ledr);

        // Unmapped store and read.
        store(A_NONE, 32'hFFFF_FFFF, 4'hF);
        push("unmap_ledr", 64'h1234_5641); check(ledr);
        push("unmap_ledg", 64'h11BB_33DD); check(ledg);
        push("unmap_lcd", 64'h0); check(lcd);
        push("unmap_hex", {8'h00, 7'h7F, 7'h00, 7'h40, 7'h79, {4{7'h7F}}}); check(hex_all());
        read(A_NONE, rd, hit);
        push("unmap_rd", 64'h0); check(rd);
        push("unmap_hit", 64'h0); check(hit);

        // Switch synchroniser latency.
        @(negedge clk);
        sw = 32'h0000_1234;
        read(A_SW, rd, hit);
        push("sw_0edge", 64'h0); check(rd);
        @(negedge clk);
        read(A_SW, rd, hit);
        push("sw_1edge", 64'h0); check(rd);
        @(negedge clk);
        read(A_SW, rd, hit);
        push("sw_2edge", 64'h1234); check(rd);
        push("sw_hit", 64'h1); check(hit);
        store(A_SW, 32'hFFFF_FFFF, 4'hF);
        read(A_SW, rd, hit);
        push("sw_ro", 64'h1234); check(rd);

        // Same-cycle store and load to LCD.
        store(A_LCD, 32'hCAFE_0001, 4'hF);
        push("lcd_store", 64'hCAFE_0001); check(lcd);
        @(negedge clk);
        bus.i_lsu_addr  = A_LCD;
        bus.i_lsu_wdata = 32'h0BAD_F00D;
        bus.i_lsu_bmask = 4'hF;
        bus.i_lsu_wren  = 1'b1;
        #1;
        push("collide_old", 64'hCAFE_0001); check(bus.o_lsu_rdata);
        @(negedge clk);
        bus.i_lsu_wren = 1'b0;
        #1;
        push("collide_new", 64'h0BAD_F00D); check(bus.o_lsu_rdata);
        push("collide_lcd", 64'h0BAD_F00D); check(lcd);

        // Reset asserted during a pending store: the store is lost.
        @(negedge clk);
        bus.i_lsu_addr  = A_LEDR;
        bus.i_lsu_wdata = 32'h5555_5555;
        bus.i_lsu_bmask = 4'hF;
        bus.i_lsu_wren  = 1'b1;
        #2 reset = 1'b1;
        #1;
        push("rst2_ledr", 64'h0); check(ledr);
        push("rst2_ledg", 64'h0); check(ledg);
        push("rst2_lcd", 64'h0);  check(lcd);
        push("rst2_hex", {8'h00, {8{7'h7F}}}); check(hex_all());
        push("rst2_sw", 64'h0); check(bus.o_lsu_rdata);
        @(negedge clk);
        push("rst2_store_lost", 64'h0); check(ledr);
        bus.i_lsu_wren = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        push("rst2_after", 64'h0); check(ledr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
